// File: rtl/rd_resp_if.sv
// Read-response bus: AXI4 R-channel beats in, 128-bit packet words out to the read FIFO.
interface rd_resp_if #(
  parameter int unsigned data_wid = 32,
  parameter int unsigned id_wid   = 4
);
  localparam int unsigned word_wid = 128;
  localparam int unsigned resp_wid = 4;

  logic                rd_rsp_en;
  logic [id_wid-1:0]   rid;
  logic [data_wid-1:0] rdata;
  logic [resp_wid-1:0] rresp;
  logic                rlast;
  logic                rready;
  logic                fifo_full;
  logic                write_enable;
  logic [word_wid-1:0] fifo_wdata;
  logic                pkt_done;

  modport master (
    output rd_rsp_en, rid, rdata, rresp, rlast, fifo_full,
    input  rready, write_enable, fifo_wdata, pkt_done
  );

  modport slave (
    input  rd_rsp_en, rid, rdata, rresp, rlast, fifo_full,
    output rready, write_enable, fifo_wdata, pkt_done
  );
endinterface

// File: rtl/rd_resp_encoder.sv
// Packs AXI4 read-data beats into SOP/EOP framed 128-bit words:
// header, ceil(beats/4) data words, trailer with beat count, ID, worst response.
module rd_resp_encoder #(
  parameter int unsigned data_wid = 32,
  parameter int unsigned id_wid   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rd_resp_if.slave    bus
);
  localparam int unsigned word_wid = 128;
  localparam int unsigned lane_wid = 32;
  localparam int unsigned resp_wid = 4;
  localparam int unsigned cnt_wid  = 9;
  localparam int unsigned idx_wid  = 2;
  localparam logic [7:0]  sop      = 8'hAA;
  localparam logic [7:0]  eop      = 8'h53;

  typedef enum logic [2:0] {IDLE, HDR, COLLECT, FLUSH, TRAILER} state_t;

  state_t               state;
  logic [id_wid-1:0]    cap_id;
  logic [resp_wid-1:0]  cap_resp;
  logic [resp_wid-1:0]  resp_acc;
  logic [word_wid-1:0]  acc;
  logic [idx_wid-1:0]   idx;
  logic [cnt_wid-1:0]   beat_cnt;
  logic                 last_seen;
  logic                 ovr;
  logic                 cnt_max;
  logic [word_wid-1:0]  word_c;
  logic                 wr_c;

  // Beat 256 without rlast forces the packet closed.
  assign cnt_max = (beat_cnt == cnt_wid'(255));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_id    <= '0;
      cap_resp  <= '0;
      resp_acc  <= '0;
      acc       <= '0;
      idx       <= '0;
      beat_cnt  <= '0;
      last_seen <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.rd_rsp_en) begin
            cap_id   <= bus.rid;
            cap_resp <= bus.rresp;
            state    <= HDR;
          end
        end
        HDR: begin
          if (!bus.fifo_full) state <= COLLECT;
        end
        COLLECT: begin
          if (bus.rd_rsp_en) begin
            acc[{idx, 5'd0} +: lane_wid] <= lane_wid'(bus.rdata);
            idx       <= idx + idx_wid'(1);
            beat_cnt  <= beat_cnt + cnt_wid'(1);
            if (bus.rresp > resp_acc) resp_acc <= bus.rresp;
            last_seen <= bus.rlast || cnt_max;
            ovr       <= cnt_max && !bus.rlast;
            if (idx == idx_wid'(3) || bus.rlast || cnt_max) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!bus.fifo_full) begin
            acc   <= '0;
            idx   <= '0;
            state <= last_seen ? TRAILER : COLLECT;
          end
        end
        TRAILER: begin
          if (!bus.fifo_full) begin
            beat_cnt  <= '0;
            resp_acc  <= '0;
            ovr       <= 1'b0;
            last_seen <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output word and strobe decoded from the current state; held while the FIFO is full.
  always_comb begin
    word_c = '0;
    wr_c   = 1'b0;
    unique case (state)
      HDR: begin
        word_c = {sop, 4'(cap_id), cap_resp, 112'h0};
        wr_c   = !bus.fifo_full;
      end
      FLUSH: begin
        word_c = acc;
        wr_c   = !bus.fifo_full;
      end
      TRAILER: begin
        word_c = {eop, 8'(beat_cnt - cnt_wid'(1)), 4'(cap_id), resp_acc, ovr, 103'h0};
        wr_c   = !bus.fifo_full;
      end
      default: ;
    endcase
  end

  assign bus.fifo_wdata   = word_c;
  assign bus.write_enable = wr_c;
  assign bus.rready       = (state == COLLECT);
  assign bus.pkt_done     = (state == TRAILER) && !bus.fifo_full;
endmodule

// File: tb/tb_rd_resp_encoder.sv
// Directed bench for rd_resp_encoder: a packet-level model predicts every FIFO word,
// a negedge monitor compares each write, and literal checks pin the model.
module tb_rd_resp_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   rr_cnt = 0;
  int   pd_cnt = 0;

  rd_resp_if #(.data_wid(32), .id_wid(4)) bus();

  rd_resp_encoder #(.data_wid(32), .id_wid(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected FIFO words and whether each one is a trailer.
  logic [127:0] exp_q[$];
  bit           trl_q[$];
  logic [127:0] got_q[$];

  // Packet-level model state.
  bit          m_in_pkt = 1'b0;
  int          m_cnt = 0;
  int          m_nl = 0;
  logic [3:0]  m_id = '0;
  logic [3:0]  m_worst = '0;
  logic [31:0] m_lane [4];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void model_beat(input logic [3:0] id, input logic [31:0] d,
                                     input logic [3:0] r, input bit last);
    bit close;
    if (!m_in_pkt) begin
      m_in_pkt = 1'b1;
      m_id = id; m_cnt = 0; m_nl = 0; m_worst = '0;
      for (int i = 0; i < 4; i++) m_lane[i] = '0;
      exp_q.push_back({8'hAA, id, r, 112'h0});
      trl_q.push_back(1'b0);
    end
    m_lane[m_nl] = d;
    m_nl++;
    m_cnt++;
    if (r > m_worst) m_worst = r;
    close = last || (m_cnt == 256);
    if (m_nl == 4 || close) begin
      exp_q.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
      trl_q.push_back(1'b0);
      for (int i = 0; i < 4; i++) m_lane[i] = '0;
      m_nl = 0;
    end
    if (close) begin
      exp_q.push_back({8'h53, 8'(m_cnt - 1), m_id, m_worst, (m_cnt == 256) && !last, 103'h0});
      trl_q.push_back(1'b1);
      m_in_pkt = 1'b0;
    end
  endfunction

  // Monitor: every FIFO write is checked against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rready) rr_cnt++;
      if (bus.pkt_done) pd_cnt++;
      if (bus.write_enable) begin
        got_q.push_back(bus.fifo_wdata);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %h expected no write", bus.fifo_wdata);
        end else begin
          chk("fifo_word", bus.fifo_wdata, exp_q.pop_front());
          chk("pkt_done_on_write", 128'(bus.pkt_done), 128'(trl_q.pop_front()));
        end
      end else begin
        chk("pkt_done_idle", 128'(bus.pkt_done), 128'd0);
      end
    end
  end

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d,
                           input logic [3:0] r, input bit last);
    int n = 0;
    model_beat(id, d, r, last);
    bus.rd_rsp_en = 1'b1; bus.rid = id; bus.rdata = d; bus.rresp = r; bus.rlast = last;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rready && n < 500);
    chk("beat_accept", 128'(bus.rready), 128'd1);
    @(posedge clk); #1;
    bus.rd_rsp_en = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk({nm, "_drained"}, 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int pd0;
    bus.rd_rsp_en = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
    bus.rlast = 1'b0; bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rready", 128'(bus.rready), 128'd0);
    chk("rst_we", 128'(bus.write_enable), 128'd0);
    chk("rst_wdata", bus.fifo_wdata, 128'd0);
    chk("rst_pkt_done", 128'(bus.pkt_done), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat
    b = got_q.size(); pd0 = pd_cnt;
    send_beat(4'h3, 32'hDEADBEEF, 4'h0, 1'b1);
    wait_drain("single");
    chk("single_hdr", got_q[b], 128'hAA30_0000_0000_0000_0000_0000_0000_0000);
    chk("single_data", got_q[b+1], 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    chk("single_trl", got_q[b+2], 128'h5300_3000_0000_0000_0000_0000_0000_0000);
    chk("single_pkt_done_cnt", 128'(pd_cnt - pd0), 128'd1);

    // 8-beat burst, data 1..8
    b = got_q.size(); rr_cnt = 0;
    for (int i = 1; i <= 8; i++) send_beat(4'h5, 32'(i), 4'h0, i == 8);
    wait_drain("burst8");
    chk("burst8_w1", got_q[b+1], 128'h00000004_00000003_00000002_00000001);
    chk("burst8_w2", got_q[b+2], 128'h00000008_00000007_00000006_00000005);
    chk("burst8_trl", got_q[b+3], 128'h5307_5000_0000_0000_0000_0000_0000_0000);
    chk("burst8_rready_cycles", 128'(rr_cnt), 128'd8);

    // 5 beats, worst response on beat 3
    b = got_q.size();
    for (int i = 0; i < 5; i++)
      send_beat(4'h9, 32'hA0 + 32'(i), (i == 2) ? 4'h2 : 4'h0, i == 4);
    wait_drain("burst5");
    chk("burst5_w2", got_q[b+2], 128'h0000_0000_0000_0000_0000_0000_0000_00A4);
    chk("burst5_trl", got_q[b+3], 128'h5304_9200_0000_0000_0000_0000_0000_0000);

    // FIFO full held while the first data word sits in FLUSH
    b = got_q.size();
    for (int i = 0; i < 4; i++) send_beat(4'h6, 32'h10 + 32'(i), 4'h1, 1'b0);
    bus.fifo_full = 1'b1;
    bus.rd_rsp_en = 1'b1; bus.rid = 4'h6; bus.rdata = 32'h14; bus.rresp = 4'h1; bus.rlast = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_we", 128'(bus.write_enable), 128'd0);
      chk("stall_rready", 128'(bus.rready), 128'd0);
      chk("stall_wdata", bus.fifo_wdata, 128'h00000013_00000012_00000011_00000010);
    end
    @(posedge clk); #1;
    bus.fifo_full = 1'b0;
    send_beat(4'h6, 32'h14, 4'h1, 1'b0);
    send_beat(4'h6, 32'h15, 4'h1, 1'b1);
    wait_drain("stall");
    chk("stall_w2", got_q[b+2], 128'h0000_0000_0000_0000_0000_0015_0000_0014);
    chk("stall_trl", got_q[b+3], 128'h5305_6100_0000_0000_0000_0000_0000_0000);

    // 256 beats without rlast, then one more beat opens a new packet
    b = got_q.size();
    for (int i = 0; i < 256; i++) send_beat(4'h7, 32'(i), 4'h0, 1'b0);
    send_beat(4'h7, 32'hCAFE, 4'h0, 1'b1);
    wait_drain("ovr");
    chk("ovr_last_data", got_q[b+64], 128'h000000FF_000000FE_000000FD_000000FC);
    chk("ovr_trl", got_q[b+65], 128'h53FF_7080_0000_0000_0000_0000_0000_0000);
    chk("ovr_next_hdr", got_q[b+66], 128'hAA70_0000_0000_0000_0000_0000_0000_0000);

    // Reset after two beats of a burst
    send_beat(4'h2, 32'h21, 4'h0, 1'b0);
    send_beat(4'h2, 32'h22, 4'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rready", 128'(bus.rready), 128'd0);
    chk("mid_rst_we", 128'(bus.write_enable), 128'd0);
    chk("mid_rst_wdata", bus.fifo_wdata, 128'd0);
    chk("mid_rst_pending", 128'(exp_q.size()), 128'd0);
    m_in_pkt = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b = got_q.size();
    send_beat(4'hB, 32'h5A5A5A5A, 4'h1, 1'b1);
    wait_drain("post_rst");
    chk("post_rst_hdr", got_q[b], 128'hAAB1_0000_0000_0000_0000_0000_0000_0000);
    chk("post_rst_data", got_q[b+1], 128'h0000_0000_0000_0000_0000_0000_5A5A_5A5A);
    chk("post_rst_trl", got_q[b+2], 128'h5300_B100_0000_0000_0000_0000_0000_0000);
    chk("post_rst_count", 128'(got_q.size() - b), 128'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rd_resp_encoder.md
Name: rd_resp_encoder

Overview:
- Encodes AXI4 read-data beats returned by the BFM master into 128-bit packets and writes them into the read FIFO toward the host.
- Counterpart of the command decoder. It uses the same framing: an SOP byte 8'hAA starts a packet and an EOP byte 8'h53 ends it.
- Each packet has one header word, ceil(beats/4) data words and one trailer word.

Parameters:
- data_wid, 32, rdata width; the packing below is fixed at 32 bits per beat, 4 beats per 128-bit word.
- id_wid, 4, width of the read transaction ID.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- rd_rsp_en  input  1  read beat valid; held until accepted
- rid  input  id_wid  read ID
- rdata  input  data_wid  read data beat
- rresp  input  4  beat response
- rlast  input  1  last beat of burst
- rready  output  1  beat accepted when rd_rsp_en && rready
- fifo_full  input  1  read FIFO full
- write_enable  output  1  FIFO write strobe
- fifo_wdata  output  128  FIFO write word
- pkt_done  output  1  one-cycle pulse when the trailer is written

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
  - Reset values: state IDLE, rready 0, write_enable 0, fifo_wdata 0, pkt_done 0.
  - Internal lane index, beat count, accumulators and flags all clear to 0.
- write_enable = (state is HDR, FLUSH or TRAILER) && !fifo_full, decoded combinationally.
  - fifo_wdata is 0 in every other state.
- rready = (state == COLLECT), decoded combinationally.
- States:
  - IDLE:
    - On rd_rsp_en, capture rid into cap_id and rresp into cap_resp; go to HDR.
    - No beat is consumed here.
  - HDR:
    - fifo_wdata = {8'hAA, cap_id, cap_resp, 112'h0}.
    - On write (!fifo_full), go to COLLECT.
  - COLLECT: on each accepted beat:
    - Store rdata into acc[32*idx +: 32].
    - idx <= idx+1; beat_cnt <= beat_cnt+1.
    - resp_acc <= max(resp_acc, rresp).
    - Go to FLUSH if idx==3, rlast==1, or beat_cnt==255 (the 256th beat).
    - last_seen <= rlast || (beat_cnt==255).
    - ovr <= (beat_cnt==255) && !rlast.
  - FLUSH:
    - fifo_wdata = acc; unfilled lanes read 0.
    - On write: clear acc and idx.
    - Then go to TRAILER if last_seen, else back to COLLECT.
  - TRAILER:
    - fifo_wdata = {8'h53, beat_cnt-1 [7:0], cap_id, resp_acc, ovr, 103'h0}.
    - Field positions: [127:120] EOP, [119:112] beats-1, [111:108] ID, [107:104] worst resp, [103] overrun.
    - On write: pulse pkt_done, clear beat_cnt, resp_acc, ovr and last_seen; go to IDLE.
- Beat count:
  - beat_cnt is 9-bit internally.
  - The trailer carries beats-1 in 8 bits, same encoding as arlen.
  - A burst of 256 beats without rlast is closed forcibly with ovr=1. Later beats start a new packet.
- rid change mid-burst is ignored; cap_id is used throughout.
- Backpressure:
  - While fifo_full=1 in HDR, FLUSH or TRAILER, state and fifo_wdata hold stable and write_enable stays 0.
  - No beats are accepted outside COLLECT, so rdata is never dropped.
- Throughput: one beat per cycle in COLLECT; one idle-to-bus cycle per flushed word.
- Latency: the header is written no earlier than 1 cycle after rd_rsp_en is first seen in IDLE.
- Reset mid-packet:
  - Returns to IDLE immediately; the partial packet is abandoned and no trailer is emitted.
  - rready and write_enable drop in the same cycle reset is sampled.

Test Plan:
- Single beat: rid=4'h3, rdata=32'hDEADBEEF, rresp=0, rlast=1.
  - Expect 3 writes: {AA,3,0,0…}, then 128'h…0000_DEADBEEF (lane0), then trailer with [119:112]=8'h00, [111:108]=3, [107:104]=0.
  - pkt_done pulses once.
- 8-beat burst, data 1..8, rlast on beat 8.
  - Expect header, then {4,3,2,1}, then {8,7,6,5} (beat0 in [31:0]), then trailer with [119:112]=8'h07.
  - rready high 4 cycles per data word.
- 5-beat burst with rresp on beat 3 = 2, others 0.
  - Expect the second data word to have lanes 1-3 = 0.
  - Trailer [107:104]=2 and [119:112]=8'h04.
- fifo_full asserted for 5 cycles while in FLUSH.
  - write_enable stays 0 and rready stays 0.
  - fifo_wdata is stable; no beat is lost after release; the packet is identical to the unstalled case.
- 256 beats with rlast never set.
  - Trailer has [119:112]=8'hFF and [103]=1.
  - The next beat opens a new packet with a fresh AA header.
- rst_n pulsed low during COLLECT after 2 beats.
  - Next cycle: state IDLE, rready=0, write_enable=0.
  - A following 1-beat burst produces a clean 3-word packet.
